ysyx_22050039_mdu: RTL and testbench

Iterative RV64M multiply/divide unit sitting beside the single-cycle execute stage: it accepts one M-extension operation through a valid/ready handshake, computes it over multiple cycles with a radix-2 shift-add multiplier or a restoring divider, and returns the XLEN-bit result with a passthrough tag. It generalises the execute datapath in width, supports 32-bit "W" variants, and adds back-pressure, flush, and special-case handling.

---
 rtl/ysyx_22050039_mdu.sv | 233 +++++++++++++++++++++++
 tb/tb_ysyx_22050039_mdu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_mdu.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiplier and restoring divider.
// Optional build macro YSYX_22050039_MDU_FASTPATH_EN lets trivial operations skip iteration.
module ysyx_22050039_mdu #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] out_tag
);

  localparam int   CW    = $clog2(XLEN + 1);
  localparam logic HAS_W = (XLEN == 64);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic [XLEN-1:0]   result_reg;
  logic [TAGW-1:0]   tag_reg;
  logic [TAGW-1:0]   out_tag_reg;
  logic [CW-1:0]     cnt_reg;
  logic [CW-1:0]     iter_reg;
  logic [2:0]        op_reg;
  logic              w_reg;
  logic              neg_reg;
  logic              div_zero_reg;
  logic              ovf_reg;
  logic              mul_zero_reg;
  logic [XLEN-1:0]   a_raw_reg;
  logic [2*XLEN-1:0] prod_reg;
  logic [2*XLEN-1:0] mcand_reg;
  logic [XLEN-1:0]   mplier_reg;
  logic [XLEN-1:0]   quot_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   dvsr_reg;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] r;
    r = v;
    for (int i = 32; i < XLEN; i++) r[i] = v[31];
    return r;
  endfunction

  // Request decode: operands are reduced to magnitudes in the active width (32 for W, XLEN otherwise).
  logic            w_in;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            is_div_in;
  logic            div_zero_in;
  logic            ovf_in;
  logic            mul_zero_in;
  logic            fast_in;
  logic            neg_in;
  logic [XLEN-1:0] mask;
  logic [XLEN-1:0] min_val;
  logic [XLEN-1:0] a_val;
  logic [XLEN-1:0] b_val;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [CW-1:0]   iter_in;

  always_comb begin
    w_in        = op[3] & HAS_W;
    mask        = w_in ? XLEN'(32'hFFFF_FFFF) : '1;
    min_val     = w_in ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    a_val       = src1 & mask;
    b_val       = src2 & mask;
    a_signed    = (op[2:0] == 3'd1) | (op[2:0] == 3'd2) | (op[2:0] == 3'd4) | (op[2:0] == 3'd6);
    b_signed    = (op[2:0] == 3'd1) | (op[2:0] == 3'd4) | (op[2:0] == 3'd6);
    a_neg       = a_signed & (w_in ? src1[31] : src1[XLEN-1]);
    b_neg       = b_signed & (w_in ? src2[31] : src2[XLEN-1]);
    a_mag       = (a_neg ? -a_val : a_val) & mask;
    b_mag       = (b_neg ? -b_val : b_val) & mask;
    is_div_in   = op[2];
    // A remainder takes the dividend's sign; products and quotients take the xor.
    neg_in      = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero_in = is_div_in & (b_val == '0);
    ovf_in      = is_div_in & b_signed & (a_val == min_val) & (b_val == mask);
    mul_zero_in = ~is_div_in & ((a_val == '0) | (b_val == '0));
`ifdef YSYX_22050039_MDU_FASTPATH_EN
    fast_in     = div_zero_in | ovf_in | mul_zero_in;
`else
    fast_in     = 1'b0;
`endif
    iter_in     = fast_in ? CW'(1) : (w_in ? CW'(32) : CW'(XLEN));
  end

  // One restoring-division step.
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem_reg, quot_reg[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_reg};
  end

  // Final sign fix-up, half selection and special-case override.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix;
  logic [XLEN-1:0]   r_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN-1:0]   div_res;
  logic [XLEN-1:0]   res_n;
  logic [XLEN-1:0]   res_fin;

  always_comb begin
    prod_fix = neg_reg ? -prod_reg : prod_reg;
    q_fix    = neg_reg ? -quot_reg : quot_reg;
    r_fix    = neg_reg ? -rem_reg : rem_reg;
    if (op_reg == 3'd0)
      mul_res = prod_fix[XLEN-1:0];
    else if (w_reg)
      mul_res = prod_fix[XLEN-1:0] >> 32;
    else
      mul_res = prod_fix[2*XLEN-1:XLEN];
    if (op_reg[1])
      div_res = div_zero_reg ? a_raw_reg : (ovf_reg ? '0 : r_fix);
    else
      div_res = div_zero_reg ? '1 : (ovf_reg ? a_raw_reg : q_fix);
    if (op_reg[2])
      res_n = div_res;
    else
      res_n = mul_zero_reg ? '0 : mul_res;
    res_fin = w_reg ? sext32(res_n) : res_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      tag_reg       <= '0;
      out_tag_reg   <= '0;
      cnt_reg       <= '0;
      iter_reg      <= '0;
      op_reg        <= '0;
      w_reg         <= 1'b0;
      neg_reg       <= 1'b0;
      div_zero_reg  <= 1'b0;
      ovf_reg       <= 1'b0;
      mul_zero_reg  <= 1'b0;
      a_raw_reg     <= '0;
      prod_reg      <= '0;
      mcand_reg     <= '0;
      mplier_reg    <= '0;
      quot_reg      <= '0;
      rem_reg       <= '0;
      dvsr_reg      <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg    <= BUSY;
            in_ready_reg <= 1'b0;
            cnt_reg      <= '0;
            iter_reg     <= iter_in;
            op_reg       <= op[2:0];
            w_reg        <= w_in;
            tag_reg      <= in_tag;
            neg_reg      <= neg_in;
            div_zero_reg <= div_zero_in;
            ovf_reg      <= ovf_in;
            mul_zero_reg <= mul_zero_in;
            a_raw_reg    <= a_val;
            prod_reg     <= '0;
            mcand_reg    <= {{XLEN{1'b0}}, a_mag};
            mplier_reg   <= b_mag;
            rem_reg      <= '0;
            // Left-align a W dividend so its MSB is the first bit shifted into the remainder.
            quot_reg     <= a_mag << (w_in ? (XLEN - 32) : 0);
            dvsr_reg     <= b_mag;
          end
        end
        BUSY: begin
          if (cnt_reg == iter_reg) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            result_reg    <= res_fin;
            out_tag_reg   <= tag_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (op_reg[2]) begin
              rem_reg  <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
              quot_reg <= {quot_reg[XLEN-2:0], ~diff[XLEN]};
            end else begin
              if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
              mcand_reg  <= mcand_reg << 1;
              mplier_reg <= mplier_reg >> 1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_ysyx_22050039_mdu.sv
// Self-checking bench for ysyx_22050039_mdu (XLEN=64): directed vector table, random ops
// against an arithmetic reference model, plus hold, flush and asynchronous reset sequences.
module tb_ysyx_22050039_mdu;
  localparam int XLEN = 64;
  localparam int TAGW = 5;

`ifdef YSYX_22050039_MDU_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [TAGW-1:0] out_tag;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ysyx_22050039_mdu #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  tag;
    logic [63:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, exp);
    else
      passed++;
  endtask

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: plain wide signed arithmetic with the RISC-V special-case rules.
  function automatic logic [63:0] ref_model(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b);
    logic              w;
    logic [2:0]        f;
    logic              sa;
    logic              sb;
    logic signed [129:0] ea;
    logic signed [129:0] eb;
    logic signed [129:0] p;
    logic signed [129:0] q;
    logic signed [129:0] r;
    logic signed [129:0] minv;
    logic [63:0]       raw;
    logic [63:0]       res;
    w  = o[3];
    f  = o[2:0];
    sa = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    sb = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    if (w) begin
      if (sa) ea = $signed(a[31:0]); else ea = $signed({1'b0, a[31:0]});
      if (sb) eb = $signed(b[31:0]); else eb = $signed({1'b0, b[31:0]});
      minv = $signed(32'h8000_0000);
      raw  = sext32(a[31:0]);
    end else begin
      if (sa) ea = $signed(a); else ea = $signed({1'b0, a});
      if (sb) eb = $signed(b); else eb = $signed({1'b0, b});
      minv = $signed(64'h8000_0000_0000_0000);
      raw  = a;
    end
    if (!f[2]) begin
      p = ea * eb;
      if (w) res = sext32((f == 3'd0) ? p[31:0] : p[63:32]);
      else   res = (f == 3'd0) ? p[63:0] : p[127:64];
    end else if (eb == 0) begin
      res = f[1] ? raw : 64'hFFFF_FFFF_FFFF_FFFF;
    end else if (sa && sb && ea == minv && eb == -1) begin
      res = f[1] ? 64'd0 : raw;
    end else begin
      q = ea / eb;
      r = ea % eb;
      if (f[1]) res = w ? sext32(r[31:0]) : r[63:0];
      else      res = w ? sext32(q[31:0]) : q[63:0];
    end
    return res;
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 7))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h8000_0000_0000_0000;
      3:       v = 64'h0000_0000_8000_0000;
      4:       v = 64'($urandom_range(0, 20));
      5:       v = {32'd0, $urandom()};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  task automatic start_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    op = o; src1 = a; src2 = b; in_tag = t; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts edges after the acceptance edge until out_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 300);
    if (!out_valid) begin
      total++;
      $display("FAIL timeout: out_valid not seen after %0d cycles, required within 300", lat);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic add_vec(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] t, input logic [63:0] e, input bit sp);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.tag = t; v.exp = e; v.special = sp;
    vecs.push_back(v);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          exp_lat;
    int          seen;
    logic [3:0]  o;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] e;
    logic [4:0]  t;

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src1 = '0; src2 = '0; in_tag = '0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_out_tag", out_tag, 0);
    rst = 1'b1;

    add_vec(4'h0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 0);
    add_vec(4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    add_vec(4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd0, 0);
    add_vec(4'h4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 64'h8000_0000_0000_0000, 1);
    add_vec(4'h6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'd0, 1);
    add_vec(4'h5, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_vec(4'h7, 64'd5, 64'd0, 5'd11, 64'd5, 1);
    add_vec(4'hC, 64'h0000_0001_8000_0000, 64'd2, 5'd12, 64'hFFFF_FFFF_C000_0000, 0);
    add_vec(4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add_vec(4'h4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd14, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    add_vec(4'h6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    add_vec(4'h8, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    add_vec(4'h0, 64'd0, 64'h1234, 5'd17, 64'd0, 1);
    add_vec(4'hE, 64'h0000_0000_8000_0000, 64'd0, 5'd18, 64'hFFFF_FFFF_8000_0000, 1);
    add_vec(4'h5, 64'd100, 64'd7, 5'd19, 64'd14, 0);
    add_vec(4'hF, 64'hFFFF_FFFF_0000_0011, 64'd5, 5'd20, 64'd2, 0);

    foreach (vecs[i]) begin
      exp_lat = (vecs[i].special && FAST) ? 2 : (vecs[i].op[3] ? 33 : 65);
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      wait_done(lat);
      check($sformatf("vec%0d_result", i), result, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].tag));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
      $display("vec%0d op=%h a=%h b=%h -> result=%h tag=%0d latency=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, result, out_tag, lat);
      handshake();
    end

    for (int i = 0; i < 40; i++) begin
      o = 4'($urandom_range(0, 15));
      a = pick();
      b = pick();
      t = 5'($urandom_range(0, 31));
      e = ref_model(o, a, b);
      start_op(o, a, b, t);
      wait_done(lat);
      check($sformatf("rand%0d_result", i), result, e);
      check($sformatf("rand%0d_tag", i), 64'(out_tag), 64'(t));
      $display("rand%0d op=%h a=%h b=%h -> result=%h expect=%h tag=%0d latency=%0d",
               i, o, a, b, result, e, out_tag, lat);
    handshake();
    end

    // Result held under back-pressure, then released.
    start_op(4'h0, 64'd3, 64'd5, 5'd25);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_result", result, 64'd15);
      check("hold_tag", 64'(out_tag), 64'd25);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    handshake();
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    $display("hold op=0 a=3 b=5 -> result=%h tag=%0d held 10 cycles", result, out_tag);

    // Flush in BUSY with a concurrent request: both the operation and the request vanish.
    start_op(4'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd21);
    repeat (19) @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 4'h0; src1 = 64'd2; src2 = 64'd3; in_tag = 5'd22;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", in_ready, 1);
    check("flush_out_valid", out_valid, 0);
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    check("flush_idle_after", in_ready, 1);
    $display("flush during busy with concurrent request -> out_valid cycles=%0d", seen);

    // Asynchronous reset mid-BUSY, checked before the next clock edge.
    start_op(4'h4, 64'd1000, 64'd7, 5'd23);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    check("async_rst_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    $display("async reset mid-busy -> in_ready=%0d out_valid=%0d result=%h", in_ready, out_valid, result);

    start_op(4'h0, 64'd6, 64'd7, 5'd24);
    wait_done(lat);
    check("post_rst_result", result, 64'd42);
    check("post_rst_latency", 64'(lat), 64'd65);
    $display("post-reset op=0 a=6 b=7 -> result=%h latency=%0d", result, lat);
    handshake();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
